custom_ip_deserializer: RTL and testbench
=========================================

# custom_ip_deserializer

Receive-side counterpart of the formatter, in the same `clk_fast` domain. It samples the 4-bit serial bus (`enable`, `data_in`, `frame_start`, `frame_end`) and reassembles each 4-cycle group into one 16-bit word, `{odd_byte, even_byte}`. Words go into an output FIFO with a valid/ready stream. The block also checks frame length and group alignment, and reports per-frame status plus sticky error flags.

## Interface
- `FRAME_GROUPS`, 324: number of groups (words) in one frame.
- `OUT_FIFO_DEPTH`, 16: output FIFO depth in words; power of two, ≥ 4.
- `START_TIMEOUT`, 16: maximum number of cycles from `frame_start` to the first data nibble.

Ports (one clock; reset is synchronous and active-high):
- `clk_fast` in 1: serial clock; all logic runs on it.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: the stream is active this cycle.
- `data_in` in 4: serial nibble.
- `frame_start` in 1: one-cycle frame-start pulse.
- `frame_end` in 1: one-cycle frame-end pulse.
- `out_valid` out 1: a word is available.
- `out_ready` in 1: consumer accepts the word.
- `out_data` out 16: `[15:8]` is the odd byte, `[7:0]` is the even byte.
- `out_last` out 1: marks word `FRAME_GROUPS-1` of a frame.
- `frame_done` out 1: one-cycle pulse at the end of each frame.
- `frame_ok` out 1: qualifies `frame_done`; 1 means the frame had no error.
- `err_len` out 1: sticky; frame length ≠ `FRAME_GROUPS`, or a start timeout occurred.
- `err_align` out 1: sticky; a partial group was seen.
- `err_ovf` out 1: sticky; a word was dropped because the FIFO was full.
- `err_clr` in 1: clears all sticky flags.
- `stat_frames` out 16: count of good frames.
- `stat_errors` out 16: count of errored frames.

## Operation
- **Bus timing.** `data_in` is valid on the cycle after the `enable` cycle it belongs to.
  - `en_q` is `enable` delayed by one register; a nibble is sampled whenever `en_q` = 1.
  - `frame_end` coincides with the last sampled nibble.
- **Phase counter.** `phase` (2 bits) counts 0..3 across sampled nibbles.
- **Bit mapping at phase p:**
  - `even[7-p]` = `data_in[3]`, `even[3-p]` = `data_in[2]`
  - `odd[7-p]` = `data_in[1]`, `odd[3-p]` = `data_in[0]`
- **Word completion.** At phase 3 the word is complete and is pushed if the FIFO is not full.
  - If the FIFO is full, the word is dropped and `err_ovf` is set.
  - `group_cnt` has width `$clog2(FRAME_GROUPS+1)` and saturates at `FRAME_GROUPS`.
  - Words beyond `FRAME_GROUPS` are dropped and set `err_len`.
- **FSM states:** IDLE, ARMED, CAPTURE, CLOSE.
  - IDLE: `frame_start` → ARMED. `en_q` seen in IDLE → sets `err_align`; the nibble is ignored.
  - ARMED: first `en_q` → CAPTURE, and that nibble is sampled. Timeout counter reaches `START_TIMEOUT` → set `err_len`, go to CLOSE.
  - CAPTURE: `frame_end` → CLOSE, after sampling the coincident nibble. `en_q` falling while `phase` ≠ 0 → sets `err_align`.
  - CLOSE (1 cycle): pulse `frame_done`; `frame_ok` = no error flagged during this frame. Then go to IDLE and clear the per-frame state (`phase`, `group_cnt`, partial bytes).
- **End-of-frame checks.** At `frame_end`:
  - If `phase` ≠ 0 after the final sample, the partial group is discarded and `err_align` is set.
  - If `group_cnt` ≠ `FRAME_GROUPS`, `err_len` is set.
- **Back-to-back frames.**
  - `frame_start` while in CAPTURE: the current frame closes with `err_len`, and the block re-arms on the next cycle. That start is not lost.
  - `frame_start` and `frame_end` in the same cycle: the end is processed first, then the start is latched.
- **Error flags.** `err_*` are set on error and held until `err_clr` or `rst`. If set and clear occur in the same cycle, set wins.

## Timing
- **Reset values:**
  - All outputs are 0; `out_valid` = 0; the FIFO is empty.
  - The FSM is in IDLE, `phase` = 0, and the counters are 0.
- **Latency:**
  - `enable` to sample: 1 cycle (the `data_in` register timing).
  - Push edge to `out_valid` high: 1 cycle, because the FIFO empty flag is registered.
  - `frame_end` to `frame_done`: 1 cycle.
- **Output stream:**
  - A transfer happens when `out_valid` && `out_ready`.
  - `out_data` and `out_last` are held stable while `out_valid` && !`out_ready`.
- **No input backpressure.** Input is never backpressured; overflow is the only loss mode.
- **FIFO boundary cases:**
  - A push to the full FIFO is dropped, even if a pop happens in the same cycle.
  - A simultaneous push and pop on a non-full FIFO is legal.
  - Pointers wrap modulo `OUT_FIFO_DEPTH`.

## Configuration
- Macro `CUSTOM_IP_DESER_STATS_EN`.
- **Defined:** at each `frame_done`, `stat_frames` increments if `frame_ok`, otherwise `stat_errors` increments.
  - Both counters saturate at 0xFFFF.
  - Both are cleared by `rst` only; `err_clr` does not affect them.
- **Undefined:** `stat_frames` and `stat_errors` are tied to 0 and no counter logic is built.

## Structure
- Package `custom_ip_pkg` holds:
  - `deser_state_e`
  - the `deser_err_t` packed struct (`len`, `align`, `ovf`)
  - the `ZERO_VALUE` constant.
- Sub-module `sync_fifo`:
  - parameters WIDTH and DEPTH; WIDTH = 17, carrying `out_data` plus `out_last`.
  - registered `full` and `empty` outputs.
- Top level contains the FSM, phase counter, group counter, byte assembly and error logic.

## Test plan
- **Single group.** `FRAME_GROUPS`=1; `frame_start`, then nibbles 0x9, 0x5, 0xA, 0x6, then `frame_end` with the last nibble. Required: `out_data`=0x3CA5, `out_last`=1, `frame_done`=1, `frame_ok`=1.
- **Full frame.** 324 groups streamed with `out_ready`=1. Required: 324 words in order, `out_last` on word 323 only, no `err_*` set.
- **Short frame.** `frame_end` after 10 groups. Required: `err_len`=1, `frame_ok`=0, 10 words output, no `out_last`.
- **Partial group.** Frame of 5 groups plus 2 extra nibbles. Required: `err_align`=1, 5 words output, the partial group dropped.
- **Overflow.** `OUT_FIFO_DEPTH`=16, `out_ready`=0, 20 groups. Required: 16 words stored, `err_ovf`=1; `err_clr` clears the flag to 0 on the next cycle.
- **Reset mid-frame, then timeout.**
  - `rst` pulsed at group 7: all outputs 0 and the FIFO empty.
  - Next, `frame_start` with no `enable` for 16 cycles: `err_len`=1 and a `frame_done` pulse.

Source files
------------

// File: rtl/custom_ip_pkg.sv
// Shared types and constants for the serial-nibble deserializer.
package custom_ip_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_CLOSE} deser_state_e;

  typedef struct packed {
    logic len;
    logic align;
    logic ovf;
  } deser_err_t;

  localparam logic [15:0] ZERO_VALUE = 16'h0000;
endpackage

// File: rtl/custom_ip_deserializer_if.sv
// Serial input bus plus valid/ready word stream of the deserializer.
interface custom_ip_deserializer_if;
  logic        enable;
  logic [3:0]  data_in;
  logic        frame_start;
  logic        frame_end;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;

  modport master (output enable, data_in, frame_start, frame_end, out_ready,
                  input  out_valid, out_data, out_last);
  modport slave  (input  enable, data_in, frame_start, frame_end, out_ready,
                  output out_valid, out_data, out_last);
endinterface

// File: rtl/custom_ip_deserializer_sync_fifo.sv
// Single-clock FIFO with registered full/empty; pushes to a full FIFO are dropped.
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt, cnt_nxt;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_comb begin
    cnt_nxt = cnt;
    if (do_push && !do_pop)      cnt_nxt = cnt + ONE;
    else if (!do_push && do_pop) cnt_nxt = cnt - ONE;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == CAP);
      empty <= (cnt_nxt == '0);
    end
  end
endmodule

// File: rtl/custom_ip_deserializer.sv
// Reassembles 4-nibble groups into 16-bit words with frame/alignment checking.
// Define CUSTOM_IP_DESER_STATS_EN to build the good/errored frame counters.
module custom_ip_deserializer #(
  parameter int FRAME_GROUPS   = 324,
  parameter int OUT_FIFO_DEPTH = 16,
  parameter int START_TIMEOUT  = 16
) (
  input  logic        clk_fast,
  input  logic        rst,
  custom_ip_deserializer_if.slave bus,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        err_len,
  output logic        err_align,
  output logic        err_ovf,
  input  logic        err_clr,
  output logic [15:0] stat_frames,
  output logic [15:0] stat_errors
);
  import custom_ip_pkg::*;

  localparam int GW = $clog2(FRAME_GROUPS + 1);
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam logic [GW-1:0] FG      = GW'(FRAME_GROUPS);
  localparam logic [GW-1:0] FG_LAST = GW'(FRAME_GROUPS - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(START_TIMEOUT - 1);

  deser_state_e  state;
  deser_err_t    err, set;
  logic          en_q, start_pend, frame_err;
  logic [1:0]    phase, phase_nxt, np;
  logic [7:0]    even, odd, even_nxt, odd_nxt;
  logic [GW-1:0] group_cnt, group_cnt_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          sample, restart, ends, timeout, closing, word_done, in_range, push;
  logic          fifo_full, fifo_empty;
  logic [16:0]   fifo_rdata;

  always_comb begin
    restart   = (state == S_CAPTURE) && bus.frame_start && !bus.frame_end;
    sample    = en_q && (state == S_ARMED || (state == S_CAPTURE && !restart));
    ends      = sample && bus.frame_end;
    timeout   = (state == S_ARMED) && !en_q && (tmo_cnt == TO_LAST);
    closing   = ends || restart || timeout;
    // 3-p is ~p in two bits; the upper nibble bit positions are 4 higher
    np        = ~phase;
    even_nxt  = even;
    odd_nxt   = odd;
    even_nxt[{1'b1, np}] = bus.data_in[3];
    even_nxt[{1'b0, np}] = bus.data_in[2];
    odd_nxt[{1'b1, np}]  = bus.data_in[1];
    odd_nxt[{1'b0, np}]  = bus.data_in[0];
    phase_nxt = sample ? phase + 2'd1 : phase;
    word_done = sample && (phase == 2'd3);
    in_range  = (group_cnt < FG);
    group_cnt_nxt = (word_done && in_range) ? group_cnt + GW'(1) : group_cnt;
    push      = word_done && in_range && !fifo_full;
    set.ovf   = word_done && in_range && fifo_full;
    set.len   = (word_done && !in_range) || restart || timeout ||
                (ends && group_cnt_nxt != FG);
    set.align = (state == S_IDLE && en_q) ||
                (state == S_CAPTURE && !en_q && phase != 2'd0) ||
                (ends && phase_nxt != 2'd0);
  end

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      state      <= S_IDLE;
      en_q       <= 1'b0;
      phase      <= '0;
      even       <= '0;
      odd        <= '0;
      group_cnt  <= '0;
      tmo_cnt    <= '0;
      err        <= '0;
      frame_err  <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      start_pend <= 1'b0;
    end else begin
      en_q       <= bus.enable;
      frame_done <= 1'b0;
      err.len    <= set.len   | (err.len   & ~err_clr);
      err.align  <= set.align | (err.align & ~err_clr);
      err.ovf    <= set.ovf   | (err.ovf   & ~err_clr);
      if (sample) begin
        phase     <= phase_nxt;
        even      <= even_nxt;
        odd       <= odd_nxt;
        group_cnt <= group_cnt_nxt;
      end
      if (state != S_IDLE) frame_err <= frame_err | (|set);
      if (closing) begin
        frame_done <= 1'b1;
        frame_ok   <= !(frame_err | (|set));
        start_pend <= bus.frame_start;
      end
      case (state)
        S_IDLE: if (bus.frame_start) begin
          state   <= S_ARMED;
          tmo_cnt <= '0;
        end
        S_ARMED: begin
          if (ends || timeout) state <= S_CLOSE;
          else if (en_q)       state <= S_CAPTURE;
          else                 tmo_cnt <= tmo_cnt + TW'(1);
        end
        S_CAPTURE: if (closing) state <= S_CLOSE;
        default: begin
          // a start seen with or during the close re-arms immediately
          state      <= (start_pend || bus.frame_start) ? S_ARMED : S_IDLE;
          start_pend <= 1'b0;
          tmo_cnt    <= '0;
          phase      <= '0;
          even       <= '0;
          odd        <= '0;
          group_cnt  <= '0;
          frame_err  <= 1'b0;
        end
      endcase
    end
  end

  sync_fifo #(.WIDTH(17), .DEPTH(OUT_FIFO_DEPTH)) u_fifo (
    .clk   (clk_fast),
    .rst   (rst),
    .push  (push),
    .pop   (bus.out_ready),
    .wdata ({group_cnt == FG_LAST, odd_nxt, even_nxt}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_empty ? ZERO_VALUE : fifo_rdata[15:0];
  assign bus.out_last  = !fifo_empty && fifo_rdata[16];
  assign err_len       = err.len;
  assign err_align     = err.align;
  assign err_ovf       = err.ovf;

`ifdef CUSTOM_IP_DESER_STATS_EN
  always_ff @(posedge clk_fast) begin
    if (rst) begin
      stat_frames <= ZERO_VALUE;
      stat_errors <= ZERO_VALUE;
    end else if (frame_done) begin
      if (frame_ok) begin
        if (stat_frames != 16'hFFFF) stat_frames <= stat_frames + 16'd1;
      end else if (stat_errors != 16'hFFFF) begin
        stat_errors <= stat_errors + 16'd1;
      end
    end
  end
`else
  assign stat_frames = ZERO_VALUE;
  assign stat_errors = ZERO_VALUE;
`endif
endmodule

// File: tb/tb_custom_ip_deserializer.sv
// Directed + random frames against a word-level model of the deserializer.
`timescale 1ns/1ps
module tb_custom_ip_deserializer;
`ifdef CUSTOM_IP_DESER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk_fast = 1'b0;
  logic rst;
  always #5 clk_fast = ~clk_fast;

  custom_ip_deserializer_if b0();
  custom_ip_deserializer_if b1();
  logic fd0, fo0, el0, ea0, eo0, clr0, fd1, fo1, el1, ea1, eo1, clr1;
  logic [15:0] sf0, se0, sf1, se1;

  custom_ip_deserializer dut (
    .clk_fast(clk_fast), .rst(rst), .bus(b0.slave), .frame_done(fd0), .frame_ok(fo0),
    .err_len(el0), .err_align(ea0), .err_ovf(eo0), .err_clr(clr0),
    .stat_frames(sf0), .stat_errors(se0));

  custom_ip_deserializer #(.FRAME_GROUPS(1)) dut1 (
    .clk_fast(clk_fast), .rst(rst), .bus(b1.slave), .frame_done(fd1), .frame_ok(fo1),
    .err_len(el1), .err_align(ea1), .err_ovf(eo1), .err_clr(clr1),
    .stat_frames(sf1), .stat_errors(se1));

  int errors = 0, checks = 0;
  int exp_frames = 0, exp_errs = 0;
  logic [15:0] tx_w[$];
  logic [16:0] exp_q[$], got_q[$];
  bit          done_q[$], done1_q[$];

  always @(negedge clk_fast) begin
    if (b0.out_valid && b0.out_ready) got_q.push_back({b0.out_last, b0.out_data});
    if (fd0) done_q.push_back(fo0);
    if (fd1) done1_q.push_back(fo1);
  end

  task automatic tick();
    @(posedge clk_fast); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input bit s, input logic en, input logic [3:0] d, input logic fs, input logic fe);
    if (s) begin
      b1.enable = en; b1.data_in = d; b1.frame_start = fs; b1.frame_end = fe;
    end else begin
      b0.enable = en; b0.data_in = d; b0.frame_start = fs; b0.frame_end = fe;
    end
  endtask

  // nibble p carries even[7-p], even[3-p], odd[7-p], odd[3-p]
  function automatic logic [3:0] nib_of(input logic [15:0] w, input int p);
    return {w[7-p], w[3-p], w[15-p], w[11-p]};
  endfunction

  task automatic gen(input int n);
    logic [15:0] w;
    tx_w.delete();
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      tx_w.push_back(w);
      if (i < 324) exp_q.push_back({i == 323, w});
    end
  endtask

  // cut > 0 stops after that many bus cycles with no frame_end
  task automatic send(input int extra, input bit no_start, input bit chain, input int cut);
    logic [3:0] nibs[$];
    int n;
    foreach (tx_w[i]) for (int p = 0; p < 4; p++) nibs.push_back(nib_of(tx_w[i], p));
    for (int k = 0; k < extra; k++) nibs.push_back(4'($urandom));
    n = nibs.size();
    if (!no_start) begin drv(0, 1'b0, 4'h0, 1'b1, 1'b0); tick(); end
    for (int i = 0; i <= n; i++) begin
      if (cut > 0 && i >= cut) break;
      drv(0, i < n, (i > 0) ? nibs[i-1] : 4'h0, chain && (i == n), (cut == 0) && (i == n));
      tick();
    end
    drv(0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic wait_done(input int n, input int budget, output int c);
    c = 0;
    while (done_q.size() < n && c < budget) begin tick(); c++; end
    chk("frame_done_seen", done_q.size(), n);
  endtask

  task automatic cmp_words(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), {15'd0, got_q[i]}, {15'd0, exp_q[i]});
  endtask

  task automatic clear();
    got_q.delete(); exp_q.delete(); done_q.delete();
  endtask

  task automatic pulse_clr();
    clr0 = 1'b1; tick(); clr0 = 1'b0;
  endtask

  initial begin
    int c;
    rst = 1'b1; clr0 = 1'b0; clr1 = 1'b0;
    b0.out_ready = 1'b1; b1.out_ready = 1'b0;
    drv(0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_valid", b0.out_valid, 0);
    chk("rst_data", b0.out_data, 0);
    chk("rst_last", b0.out_last, 0);
    chk("rst_done", fd0, 0);
    chk("rst_ok", fo0, 0);
    chk("rst_errs", {el0, ea0, eo0}, 0);
    chk("rst_stats", {sf0, se0}, 0);
    rst = 1'b0; tick();

    // single group on the FRAME_GROUPS=1 instance, nibbles straight from the bus example
    drv(1, 0, 4'h0, 1, 0); tick();
    drv(1, 1, 4'h0, 0, 0); tick();
    drv(1, 1, 4'h9, 0, 0); tick();
    drv(1, 1, 4'h5, 0, 0); tick();
    drv(1, 1, 4'hA, 0, 0); tick();
    drv(1, 0, 4'h6, 0, 1); tick();
    drv(1, 0, 4'h0, 0, 0);
    repeat (3) tick();
    chk("g1_done", done1_q.size(), 1);
    chk("g1_ok", (done1_q.size() > 0) ? done1_q[0] : 1'b0, 1);
    chk("g1_valid", b1.out_valid, 1);
    chk("g1_data", b1.out_data, 16'h3CA5);
    chk("g1_last", b1.out_last, 1);
    chk("g1_errs", {el1, ea1, eo1}, 0);
    chk("g1_stats", {sf1, se1}, {STATS ? 16'd1 : 16'd0, 16'd0});

    // full frame with the consumer always ready
    clear(); gen(324); send(0, 0, 0, 0);
    wait_done(1, 20, c); repeat (4) tick();
    cmp_words("full");
    chk("full_ok", (done_q.size() > 0) ? done_q[0] : 1'b0, 1);
    chk("full_errs", {el0, ea0, eo0}, 0);
    if (STATS) exp_frames++;

    // short frame
    clear(); gen(10); send(0, 0, 0, 0);
    wait_done(1, 20, c); repeat (4) tick();
    cmp_words("short");
    chk("short_ok", (done_q.size() > 0) ? done_q[0] : 1'b1, 0);
    chk("short_len", el0, 1);
    chk("short_align", ea0, 0);
    pulse_clr(); chk("short_clr", el0, 0);
    if (STATS) exp_errs++;

    // partial trailing group
    clear(); gen(5); send(2, 0, 0, 0);
    wait_done(1, 20, c); repeat (4) tick();
    cmp_words("part");
    chk("part_align", ea0, 1);
    chk("part_ok", (done_q.size() > 0) ? done_q[0] : 1'b1, 0);
    pulse_clr(); chk("part_clr", {el0, ea0}, 0);
    if (STATS) exp_errs++;

    // overflow with a stalled consumer
    clear(); b0.out_ready = 1'b0; gen(20);
    while (exp_q.size() > 16) void'(exp_q.pop_back());
    send(0, 0, 0, 0);
    wait_done(1, 20, c); repeat (2) tick();
    chk("ovf_flag", eo0, 1);
    chk("ovf_valid", b0.out_valid, 1);
    chk("ovf_hold", b0.out_data, exp_q[0][15:0]);
    pulse_clr();
    chk("ovf_clr", eo0, 0);
    b0.out_ready = 1'b1; repeat (25) tick();
    cmp_words("ovf");
    if (STATS) exp_errs++;

    // frame_end coincident with the next frame_start
    clear(); gen(3); send(0, 0, 1, 0);
    gen(2); send(0, 1, 0, 0);
    wait_done(2, 20, c); repeat (4) tick();
    cmp_words("chain");
    chk("chain_ok", {(done_q.size() > 1) ? done_q[0] : 1'b1, (done_q.size() > 1) ? done_q[1] : 1'b1}, 0);
    if (STATS) exp_errs += 2;
    pulse_clr();
    chk("stats_frames", sf0, exp_frames);
    chk("stats_errors", se0, exp_errs);

    // reset at group 7 of a stalled frame
    clear(); b0.out_ready = 1'b0; gen(20); send(0, 0, 0, 1 + 7 * 4);
    rst = 1'b1; tick(); tick();
    chk("mid_rst_valid", b0.out_valid, 0);
    chk("mid_rst_data", {b0.out_last, b0.out_data}, 0);
    chk("mid_rst_flags", {fd0, fo0, el0, ea0, eo0}, 0);
    chk("mid_rst_stats", {sf0, se0}, 0);
    rst = 1'b0; b0.out_ready = 1'b1; tick();
    exp_frames = 0; exp_errs = 0;

    // start with no data: timeout
    clear();
    drv(0, 0, 4'h0, 1, 0); tick(); drv(0, 0, 4'h0, 0, 0);
    wait_done(1, 40, c);
    chk("tmo_window", (c >= 16 && c <= 18), 1);
    chk("tmo_len", el0, 1);
    chk("tmo_ok", (done_q.size() > 0) ? done_q[0] : 1'b1, 0);
    chk("tmo_valid", b0.out_valid, 0);
    tick();
    if (STATS) exp_errs++;
    chk("tmo_stats", {sf0, se0}, {16'(exp_frames), 16'(exp_errs)});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
